// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: writeback collector for the register file write port.
// Two in-order FIFOs (ALU, load/store) feed a round-robin arbiter that
// commits at most one result per cycle into a registered rf_* stage.
// pend_a/pend_b report registers whose writes are still queued or staged.
// Optional build macro WB_STATS_EN adds commit_cnt / conflict_cnt counters.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    output logic             rf_load,
    output logic [4:0]       rf_dest,
    output logic [WIDTH-1:0] rf_in,
    input  logic [4:0]       q_a,
    input  logic [4:0]       q_b,
    output logic             pend_a,
    output logic             pend_b
`ifdef WB_STATS_EN
    ,
    output logic [31:0]      commit_cnt,
    output logic [31:0]      conflict_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Source index 0 is the ALU, 1 is the load/store unit.
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    logic [4:0]       rd_mem_q  [0:1][0:DEPTH-1];
    logic [WIDTH-1:0] dat_mem_q [0:1][0:DEPTH-1];
    logic [PW-1:0]    wp_q [0:1];
    logic [PW-1:0]    wp_d [0:1];
    logic [PW-1:0]    rp_q [0:1];
    logic [PW-1:0]    rp_d [0:1];
    logic [PW-1:0]    occ_s [0:1];
    logic             rr_q;
    logic             rr_d;
    logic             rf_load_q;
    logic [4:0]       rf_dest_q;
    logic [WIDTH-1:0] rf_in_q;

    logic [1:0]       in_valid_s;
    logic [4:0]       in_rd_s   [0:1];
    logic [WIDTH-1:0] in_data_s [0:1];
    logic [1:0]       full_s;
    logic [1:0]       empty_s;
    logic [1:0]       push_s;
    logic [1:0]       pop_s;
    logic             sel_s;
    logic             grant_s;
    logic [4:0]       head_rd_s;
    logic [WIDTH-1:0] head_data_s;
    logic             pend_a_s;
    logic             pend_b_s;

    assign in_valid_s   = {mem_valid, alu_valid};
    assign in_rd_s[0]   = alu_rd;
    assign in_rd_s[1]   = mem_rd;
    assign in_data_s[0] = alu_data;
    assign in_data_s[1] = mem_data;

    // FIFO status, push qualification (rd==0 is accepted but dropped) and pointer next-state.
    always_comb begin
        full_s  = 2'b00;
        empty_s = 2'b00;
        push_s  = 2'b00;
        for (int s = 0; s < 2; s++) begin
            empty_s[s] = (wp_q[s] == rp_q[s]);
            full_s[s]  = (wp_q[s][AW] != rp_q[s][AW]) &&
                         (wp_q[s][AW-1:0] == rp_q[s][AW-1:0]);
            push_s[s]  = in_valid_s[s] && !full_s[s] && (in_rd_s[s] != 5'd0);
            occ_s[s]   = wp_q[s] - rp_q[s];
            wp_d[s]    = wp_q[s] + {{AW{1'b0}}, push_s[s]};
            rp_d[s]    = rp_q[s] + {{AW{1'b0}}, pop_s[s]};
        end
    end

    // Ready depends on occupancy only, never on a same-cycle pop.
    assign alu_ready = !full_s[0];
    assign mem_ready = !full_s[1];

    // Round-robin choice: on contention pop the source not last granted.
    always_comb begin
        sel_s   = SRC_ALU;
        grant_s = 1'b0;
        case (~empty_s)
            2'b11: begin
                sel_s   = ~rr_q;
                grant_s = 1'b1;
            end
            2'b01: begin
                sel_s   = SRC_ALU;
                grant_s = 1'b1;
            end
            2'b10: begin
                sel_s   = SRC_MEM;
                grant_s = 1'b1;
            end
            default: begin
                sel_s   = SRC_ALU;
                grant_s = 1'b0;
            end
        endcase
        pop_s = grant_s ? (sel_s ? 2'b10 : 2'b01) : 2'b00;
        rr_d  = grant_s ? sel_s : rr_q;
    end

    assign head_rd_s   = rd_mem_q[sel_s][rp_q[sel_s][AW-1:0]];
    assign head_data_s = dat_mem_q[sel_s][rp_q[sel_s][AW-1:0]];

    // Pointers, arbiter state and the registered commit stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                wp_q[s] <= '0;
                rp_q[s] <= '0;
            end
            rr_q      <= SRC_MEM;
            rf_load_q <= 1'b0;
            rf_dest_q <= 5'd0;
            rf_in_q   <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wp_q[s] <= wp_d[s];
                rp_q[s] <= rp_d[s];
            end
            rr_q      <= rr_d;
            rf_load_q <= grant_s;
            if (grant_s) begin
                rf_dest_q <= head_rd_s;
                rf_in_q   <= head_data_s;
            end
        end
    end

    // FIFO storage; stale contents are harmless because pointers define occupancy.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push_s[s]) begin
                rd_mem_q[s][wp_q[s][AW-1:0]]  <= in_rd_s[s];
                dat_mem_q[s][wp_q[s][AW-1:0]] <= in_data_s[s];
            end
        end
    end

    // Pending-write query over occupied FIFO slots and the output stage.
    always_comb begin
        pend_a_s = 1'b0;
        pend_b_s = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                pend_a_s = pend_a_s |
                           (({1'b0, AW'(i) - rp_q[s][AW-1:0]} < occ_s[s]) &&
                            (rd_mem_q[s][i] == q_a));
                pend_b_s = pend_b_s |
                           (({1'b0, AW'(i) - rp_q[s][AW-1:0]} < occ_s[s]) &&
                            (rd_mem_q[s][i] == q_b));
            end
        end
        pend_a_s = (pend_a_s | (rf_load_q && (rf_dest_q == q_a))) && (q_a != 5'd0);
        pend_b_s = (pend_b_s | (rf_load_q && (rf_dest_q == q_b))) && (q_b != 5'd0);
    end

    assign pend_a  = pend_a_s;
    assign pend_b  = pend_b_s;
    assign rf_load = rf_load_q;
    assign rf_dest = rf_dest_q;
    assign rf_in   = rf_in_q;

`ifdef WB_STATS_EN
    logic [31:0] commit_cnt_q;
    logic [31:0] conflict_cnt_q;

    // Commit and contention counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt_q   <= 32'd0;
            conflict_cnt_q <= 32'd0;
        end else begin
            commit_cnt_q   <= commit_cnt_q + {31'd0, grant_s};
            conflict_cnt_q <= conflict_cnt_q + {31'd0, (empty_s == 2'b00)};
        end
    end

    assign commit_cnt   = commit_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (DEPTH=2, WIDTH=32).
module tb_regfile_wb_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = 5'd0;
    logic [31:0] mem_data = 32'd0;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic [4:0]  q_a = 5'd0;
    logic [4:0]  q_b = 5'd0;
    logic        pend_a;
    logic        pend_b;
`ifdef WB_STATS_EN
    logic [31:0] commit_cnt;
    logic [31:0] conflict_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.DEPTH(2), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
        .q_a(q_a), .q_b(q_b), .pend_a(pend_a), .pend_b(pend_b)
`ifdef WB_STATS_EN
        , .commit_cnt(commit_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, then settle past the edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        ent_t qa[$];
        ent_t qm[$];
        int   alu_i;
        int   cyc;
        int   n_acc;
        int   n_commit;
        int   r;
        logic fa;
        logic fm;

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        chk("rst_load", {31'd0, rf_load}, 32'd0);
        chk("rst_dest", {27'd0, rf_dest}, 32'd0);
        chk("rst_in", rf_in, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);

        // Single ALU write
        q_a = 5'd5;
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("single_pend_e0", {31'd0, pend_a}, 32'd1);
        chk("single_load_e0", {31'd0, rf_load}, 32'd0);
        idle();
        chk("single_load_e1", {31'd0, rf_load}, 32'd1);
        chk("single_dest_e1", {27'd0, rf_dest}, 32'd5);
        chk("single_in_e1", rf_in, 32'hDEADBEEF);
        chk("single_pend_e1", {31'd0, pend_a}, 32'd1);
        idle();
        chk("single_load_e2", {31'd0, rf_load}, 32'd0);
        chk("single_pend_e2", {31'd0, pend_a}, 32'd0);

        // Tie arbitration
        do_reset();
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        idle();
        chk("tie1_dest", {27'd0, rf_dest}, 32'd1);
        chk("tie1_in", rf_in, 32'h11);
        step(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
        chk("tie1b_dest", {27'd0, rf_dest}, 32'd2);
        chk("tie1b_in", rf_in, 32'h22);
        idle();
        chk("tie2_load", {31'd0, rf_load}, 32'd1);
        chk("tie2_dest", {27'd0, rf_dest}, 32'd7);
        chk("tie2_in", rf_in, 32'h77);
        idle();
        chk("tie2b_dest", {27'd0, rf_dest}, 32'd8);
        chk("tie2b_in", rf_in, 32'h88);
        idle();
        chk("tie_idle_load", {31'd0, rf_load}, 32'd0);

        // Full / backpressure: commits 10,3,11,4,12,6
        do_reset();
        step(1'b1, 5'd10, 32'hA10, 1'b1, 5'd3, 32'hB03);
        chk("bp_mem_ready_e0", {31'd0, mem_ready}, 32'd1);
        step(1'b1, 5'd11, 32'hA11, 1'b1, 5'd4, 32'hB04);
        chk("bp_mem_ready_e1", {31'd0, mem_ready}, 32'd0);
        chk("bp_c0", {27'd0, rf_dest}, 32'd10);
        step(1'b1, 5'd12, 32'hA12, 1'b1, 5'd6, 32'hB06);
        chk("bp_c1", {27'd0, rf_dest}, 32'd3);
        chk("bp_c1_in", rf_in, 32'hB03);
        chk("bp_mem_ready_e2", {31'd0, mem_ready}, 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hB06);
        chk("bp_c2", {27'd0, rf_dest}, 32'd11);
        idle();
        chk("bp_c3", {27'd0, rf_dest}, 32'd4);
        idle();
        chk("bp_c4", {27'd0, rf_dest}, 32'd12);
        idle();
        chk("bp_c5", {27'd0, rf_dest}, 32'd6);
        chk("bp_c5_in", rf_in, 32'hB06);
        chk("bp_c5_load", {31'd0, rf_load}, 32'd1);
        idle();
        chk("bp_end_load", {31'd0, rf_load}, 32'd0);
        chk("bp_end_hold", {27'd0, rf_dest}, 32'd6);

        // rd=0 drop
        do_reset();
        q_a = 5'd0;
        step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        chk("rd0_pend", {31'd0, pend_a}, 32'd0);
        step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        chk("rd0_load1", {31'd0, rf_load}, 32'd0);
        chk("rd0_ready", {31'd0, alu_ready}, 32'd1);
        idle();
        chk("rd0_load2", {31'd0, rf_load}, 32'd0);
        idle();
        chk("rd0_load3", {31'd0, rf_load}, 32'd0);

        // Reset mid-operation
        do_reset();
        q_a = 5'd9; q_b = 5'd17;
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd17, 32'h1717);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd17, 32'h1717);
        chk("mid_pend_b_pre", {31'd0, pend_b}, 32'd1);
        chk("mid_mem_ready_pre", {31'd0, mem_ready}, 32'd0);
        do_reset();
        chk("mid_load", {31'd0, rf_load}, 32'd0);
        chk("mid_dest", {27'd0, rf_dest}, 32'd0);
        chk("mid_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("mid_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("mid_pend_a", {31'd0, pend_a}, 32'd0);
        chk("mid_pend_b", {31'd0, pend_b}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("mid_no_stale", {31'd0, rf_load}, 32'd0);
        end

        // Wrap-around with random MEM traffic
        do_reset();
        alu_i = 1; cyc = 0; n_acc = 0; n_commit = 0;
        while (cyc < 400 && !(alu_i > 20 && cyc >= 60 && !mem_valid &&
                              qa.size() == 0 && qm.size() == 0 && !rf_load)) begin
            alu_valid = (alu_i <= 20);
            alu_rd    = 5'(alu_i);
            alu_data  = 32'(alu_i * 3);
            if (!mem_valid && cyc < 60 && $urandom_range(0, 1) == 1) begin
                r         = int'($urandom_range(0, 11));
                mem_valid = 1'b1;
                mem_rd    = (r == 0) ? 5'd0 : 5'(20 + r);
                mem_data  = 32'hC000_0000 + 32'(cyc);
            end
            fa = alu_valid && alu_ready;
            fm = mem_valid && mem_ready;
            @(posedge clk); #1;
            if (rf_load) begin
                n_commit++;
                if (rf_dest >= 5'd1 && rf_dest <= 5'd20) begin
                    chk("wrap_alu_rd", {27'd0, rf_dest}, (qa.size() > 0) ? {27'd0, qa[0].rd} : 32'd0);
                    chk("wrap_alu_data", rf_in, (qa.size() > 0) ? qa[0].d : 32'hFFFF_FFFF);
                    if (qa.size() > 0) void'(qa.pop_front());
                end else begin
                    chk("wrap_mem_rd", {27'd0, rf_dest}, (qm.size() > 0) ? {27'd0, qm[0].rd} : 32'd0);
                    chk("wrap_mem_data", rf_in, (qm.size() > 0) ? qm[0].d : 32'hFFFF_FFFF);
                    if (qm.size() > 0) void'(qm.pop_front());
                end
            end
            if (fa) begin
                qa.push_back('{rd: alu_rd, d: alu_data});
                n_acc++;
                alu_i++;
            end
            if (fm) begin
                if (mem_rd != 5'd0) begin
                    qm.push_back('{rd: mem_rd, d: mem_data});
                    n_acc++;
                end
                mem_valid = 1'b0;
            end
            cyc++;
        end
        alu_valid = 1'b0;
        chk("wrap_alu_done", 32'(alu_i), 32'd21);
        chk("wrap_alu_left", 32'(qa.size()), 32'd0);
        chk("wrap_mem_left", 32'(qm.size()), 32'd0);
        chk("wrap_commits", 32'(n_commit), 32'(n_acc));
`ifdef WB_STATS_EN
        chk("wrap_commit_cnt", commit_cnt, 32'(n_acc));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
